// File: rtl/prach_ditfft3_pkg.sv
// Shared constants, index type and coefficient generator for the radix-3 DFT butterfly.
// Build option PRACH_DITFFT3_ROUND_EN selects round-half-up instead of floor in the datapath.
package prach_ditfft3_pkg;

  localparam int unsigned LATENCY = 4;

  typedef enum logic [1:0] {
    IDX_X0 = 2'd0,
    IDX_X1 = 2'd1,
    IDX_X2 = 2'd2
  } idx_e;

  // round(sqrt(3)/2 * 2^(cw-1)) as the rounded integer square root of 3 * 2^(2cw-4)
  function automatic int unsigned coef_c(input int unsigned cw);
    logic [63:0] v;
    logic [63:0] r;
    logic [63:0] b;
    v = 64'(3) << (2 * cw - 4);
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      b = r | (64'(1) << i);
      if (b * b <= v) r = b;
    end
    if (v - r * r > r) r = r + 64'(1);
    return 32'(r);
  endfunction

endpackage

// File: rtl/prach_ditfft3_cmul.sv
// sqrt(3)/2 times a complex operand: multiply stage, then Q1.(CW-1) rescale stage.
// PRACH_DITFFT3_ROUND_EN: round half-up on the rescale; otherwise floor.
module prach_ditfft3_cmul
  import prach_ditfft3_pkg::*;
#(
  parameter int unsigned IW = 19,
  parameter int unsigned CW = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [IW-1:0] a_r,
  input  logic signed [IW-1:0] a_i,
  output logic signed [IW:0]   t_r,
  output logic signed [IW:0]   t_i
);

  localparam int unsigned PW = IW + CW;
  localparam int unsigned OW = IW + 1;
  localparam logic signed [PW-1:0] COEF = PW'(coef_c(CW));
`ifdef PRACH_DITFFT3_ROUND_EN
  localparam logic signed [PW-1:0] RND = PW'(1) << (CW - 2);
`else
  localparam logic signed [PW-1:0] RND = '0;
`endif

  logic signed [PW-1:0] p_r;
  logic signed [PW-1:0] p_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r <= '0;
      p_i <= '0;
      t_r <= '0;
      t_i <= '0;
    end else begin
      p_r <= PW'(a_r) * COEF;
      p_i <= PW'(a_i) * COEF;
      t_r <= OW'((p_r + RND) >>> (CW - 1));
      t_i <= OW'((p_i + RND) >>> (CW - 1));
    end
  end

endmodule

// File: rtl/prach_ditfft3_p.sv
// Streaming 3-point DFT: collects x0..x2, emits X0..X2 on consecutive cycles, 4 cycles after x2.
// Build option PRACH_DITFFT3_ROUND_EN rounds the halving of s and the coefficient rescale.
module prach_ditfft3_p
  import prach_ditfft3_pkg::*;
#(
  parameter int unsigned DW = 18,
  parameter int unsigned CW = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din_dr,
  input  logic [DW-1:0] din_di,
  input  logic          din_dv,
  input  logic          sync_in,
  input  logic          inv,
  output logic [DW+1:0] dout_dr,
  output logic [DW+1:0] dout_di,
  output logic          dout_dv,
  output logic          sync_out,
  output logic          drop
);

  localparam int unsigned SW = DW + 1;
  localparam int unsigned OW = DW + 2;

  idx_e                 idx;
  idx_e                 idx_eff_c;
  logic                 take_x2_c;
  logic signed [DW-1:0] xin_r_c, xin_i_c;
  logic signed [DW-1:0] x0_r, x0_i, x1_r, x1_i;
  logic                 x0_sync, x0_inv;
  logic signed [DW-1:0] a0_r, a0_i;
  logic signed [SW-1:0] s_r, s_i, d_r, d_i;
  logic signed [OW-1:0] half_r_c, half_i_c;
  logic signed [OW-1:0] m_r, m_i, y0_r, y0_i;
  logic signed [OW-1:0] m3_r, m3_i, y03_r, y03_i;
  logic signed [OW-1:0] t_r, t_i;
  logic signed [OW-1:0] res0_r, res0_i, res1_r, res1_i, res2_r, res2_i;
  logic [LATENCY-1:0]   vld_p, sync_p;
  logic [LATENCY-2:0]   inv_p;
  logic [1:0]           ph;

  always_comb begin
    xin_r_c   = $signed(din_dr);
    xin_i_c   = $signed(din_di);
    idx_eff_c = sync_in ? IDX_X0 : idx;
    take_x2_c = din_dv && (idx_eff_c == IDX_X2);
`ifdef PRACH_DITFFT3_ROUND_EN
    half_r_c  = (OW'(s_r) + OW'(1)) >>> 1;
    half_i_c  = (OW'(s_i) + OW'(1)) >>> 1;
`else
    half_r_c  = OW'(s_r) >>> 1;
    half_i_c  = OW'(s_i) >>> 1;
`endif
  end

  // sample collection; a sync on x1/x2 restarts the triplet and reports the discard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= IDX_X0;
      x0_r    <= '0;
      x0_i    <= '0;
      x1_r    <= '0;
      x1_i    <= '0;
      x0_sync <= 1'b0;
      x0_inv  <= 1'b0;
      drop    <= 1'b0;
    end else begin
      drop <= din_dv && sync_in && (idx != IDX_X0);
      if (din_dv) begin
        unique case (idx_eff_c)
          IDX_X0: begin
            x0_r    <= xin_r_c;
            x0_i    <= xin_i_c;
            x0_sync <= sync_in;
            x0_inv  <= inv;
            idx     <= IDX_X1;
          end
          IDX_X1: begin
            x1_r <= xin_r_c;
            x1_i <= xin_i_c;
            idx  <= IDX_X2;
          end
          default: idx <= IDX_X0;
        endcase
      end
    end
  end

  // datapath registers run freely; only the valid pipe decides what is emitted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      sync_p <= '0;
      inv_p <= '0;
      a0_r <= '0;
      a0_i <= '0;
      s_r <= '0;
      s_i <= '0;
      d_r <= '0;
      d_i <= '0;
      m_r <= '0;
      m_i <= '0;
      y0_r <= '0;
      y0_i <= '0;
      m3_r <= '0;
      m3_i <= '0;
      y03_r <= '0;
      y03_i <= '0;
    end else begin
      vld_p  <= {vld_p[LATENCY-2:0], take_x2_c};
      sync_p <= {sync_p[LATENCY-2:0], x0_sync};
      inv_p  <= {inv_p[LATENCY-3:0], x0_inv};
      a0_r   <= x0_r;
      a0_i   <= x0_i;
      s_r    <= SW'(x1_r) + SW'(xin_r_c);
      s_i    <= SW'(x1_i) + SW'(xin_i_c);
      d_r    <= SW'(x1_r) - SW'(xin_r_c);
      d_i    <= SW'(x1_i) - SW'(xin_i_c);
      m_r    <= OW'(a0_r) - half_r_c;
      m_i    <= OW'(a0_i) - half_i_c;
      y0_r   <= OW'(a0_r) + OW'(s_r);
      y0_i   <= OW'(a0_i) + OW'(s_i);
      m3_r   <= m_r;
      m3_i   <= m_i;
      y03_r  <= y0_r;
      y03_i  <= y0_i;
    end
  end

  prach_ditfft3_cmul #(
    .IW(SW),
    .CW(CW)
  ) u_cmul (
    .clk  (clk),
    .rst_n(rst_n),
    .a_r  (d_r),
    .a_i  (d_i),
    .t_r  (t_r),
    .t_i  (t_i)
  );

  // triplet results held until the serialiser has sent X2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res0_r <= '0;
      res0_i <= '0;
      res1_r <= '0;
      res1_i <= '0;
      res2_r <= '0;
      res2_i <= '0;
    end else if (vld_p[LATENCY-2]) begin
      res0_r <= y03_r;
      res0_i <= y03_i;
      res1_r <= inv_p[LATENCY-2] ? m3_r - t_i : m3_r + t_i;
      res1_i <= inv_p[LATENCY-2] ? m3_i + t_r : m3_i - t_r;
      res2_r <= inv_p[LATENCY-2] ? m3_r + t_i : m3_r - t_i;
      res2_i <= inv_p[LATENCY-2] ? m3_i - t_r : m3_i + t_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_dr  <= '0;
      dout_di  <= '0;
      dout_dv  <= 1'b0;
      sync_out <= 1'b0;
      ph       <= 2'd0;
    end else begin
      dout_dr  <= '0;
      dout_di  <= '0;
      dout_dv  <= 1'b0;
      sync_out <= 1'b0;
      ph       <= 2'd0;
      if (vld_p[LATENCY-1]) begin
        dout_dr  <= res0_r;
        dout_di  <= res0_i;
        dout_dv  <= 1'b1;
        sync_out <= sync_p[LATENCY-1];
        ph       <= 2'd1;
      end else if (ph == 2'd1) begin
        dout_dr <= res1_r;
        dout_di <= res1_i;
        dout_dv <= 1'b1;
        ph      <= 2'd2;
      end else if (ph == 2'd2) begin
        dout_dr <= res2_r;
        dout_di <= res2_i;
        dout_dv <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prach_ditfft3_p.sv
// Bench for prach_ditfft3_p: per-triplet DFT-3 model with expected output times, checked every cycle.
// Follows PRACH_DITFFT3_ROUND_EN in the model when the macro is defined.
module tb_prach_ditfft3_p;

  localparam int unsigned DW = 18;
  localparam int unsigned CW = 18;
  localparam longint C = 113512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] din_dr, din_di;
  logic          din_dv, sync_in, inv;
  logic [DW+1:0] dout_dr, dout_di;
  logic          dout_dv, sync_out, drop;

  prach_ditfft3_p #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv),
    .sync_in(sync_in), .inv(inv),
    .dout_dr(dout_dr), .dout_di(dout_di), .dout_dv(dout_dv),
    .sync_out(sync_out), .drop(drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     cyc;
    longint r;
    longint i;
    bit     sync;
  } exp_t;

  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  bit     in_reset;
  exp_t   eq[$];
  int     dq[$];
  int     midx;
  longint br[3], bi[3];
  bit     b_sync, b_inv;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // 3-point DFT from its definition: s, d, m, t then the output combinations
  function automatic void dft3(input longint ar[3], input longint ai[3], input bit iv,
                               output longint yr[3], output longint yi[3]);
    longint sr, si, dr, di, mr, mi, tr, ti;
    sr = ar[1] + ar[2];
    si = ai[1] + ai[2];
    dr = ar[1] - ar[2];
    di = ai[1] - ai[2];
`ifdef PRACH_DITFFT3_ROUND_EN
    mr = ar[0] - ((sr + 1) >>> 1);
    mi = ai[0] - ((si + 1) >>> 1);
    tr = (C * dr + (longint'(1) << (CW - 2))) >>> (CW - 1);
    ti = (C * di + (longint'(1) << (CW - 2))) >>> (CW - 1);
`else
    mr = ar[0] - (sr >>> 1);
    mi = ai[0] - (si >>> 1);
    tr = (C * dr) >>> (CW - 1);
    ti = (C * di) >>> (CW - 1);
`endif
    yr[0] = ar[0] + sr;
    yi[0] = ai[0] + si;
    yr[1] = iv ? mr - ti : mr + ti;
    yi[1] = iv ? mi + tr : mi - tr;
    yr[2] = iv ? mr + ti : mr - ti;
    yi[2] = iv ? mi - tr : mi + tr;
  endfunction

  function automatic longint rnd_val();
    logic signed [DW-1:0] v;
    int unsigned sel;
    sel = $urandom_range(0, 7);
    v = DW'($urandom);
    if (sel == 0) v = {1'b1, {(DW-1){1'b0}}};
    else if (sel == 1) v = {1'b0, {(DW-1){1'b1}}};
    return longint'(v);
  endfunction

  // drive one valid sample at the next falling edge and advance the model
  task automatic send(input longint r, input longint i, input bit sy, input bit iv);
    longint yr[3], yi[3];
    @(negedge clk);
    din_dr = DW'(r);
    din_di = DW'(i);
    din_dv = 1'b1;
    sync_in = sy;
    inv = iv;
    if (sy && midx != 0) dq.push_back(cyc + 1);
    if (sy) midx = 0;
    br[midx] = r;
    bi[midx] = i;
    if (midx == 0) begin
      b_sync = sy;
      b_inv = iv;
    end
    if (midx == 2) begin
      dft3(br, bi, b_inv, yr, yi);
      for (int k = 0; k < 3; k++) eq.push_back('{cyc + 5 + k, yr[k], yi[k], (k == 0) && b_sync});
    end
    midx = (midx + 1) % 3;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_dv = 1'b0;
      din_dr = DW'($urandom);
      din_di = DW'($urandom);
      sync_in = 1'($urandom);
      inv = 1'($urandom);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dout_dr"}, longint'($signed(dout_dr)), 0);
    check({tag, "_dout_di"}, longint'($signed(dout_di)), 0);
    check({tag, "_dout_dv"}, longint'(dout_dv), 0);
    check({tag, "_sync_out"}, longint'(sync_out), 0);
    check({tag, "_drop"}, longint'(drop), 0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    din_dv = 1'b0;
    #2;
    in_reset = 1'b1;
    rst_n = 1'b0;
    eq.delete();
    dq.delete();
    midx = 0;
    #1;
    check_zero("mid_reset");
    repeat (n) @(negedge clk);
    #2;
    rst_n = 1'b1;
    in_reset = 1'b0;
  endtask

  // output stream compare, every falling edge outside reset
  always @(negedge clk) begin
    if (!in_reset) begin
      while (eq.size() > 0 && eq[0].cyc < cyc) begin
        check("output_time", cyc, eq[0].cyc);
        void'(eq.pop_front());
      end
      if (eq.size() > 0 && eq[0].cyc == cyc) begin
        check("dout_dv", longint'(dout_dv), 1);
        check("dout_dr", longint'($signed(dout_dr)), eq[0].r);
        check("dout_di", longint'($signed(dout_di)), eq[0].i);
        check("sync_out", longint'(sync_out), longint'(eq[0].sync));
        void'(eq.pop_front());
      end else begin
        check("idle_dout_dv", longint'(dout_dv), 0);
        check("idle_dout_dr", longint'($signed(dout_dr)), 0);
        check("idle_dout_di", longint'($signed(dout_di)), 0);
        check("idle_sync_out", longint'(sync_out), 0);
      end
      while (dq.size() > 0 && dq[0] < cyc) begin
        check("drop_time", cyc, dq[0]);
        void'(dq.pop_front());
      end
      if (dq.size() > 0 && dq[0] == cyc) begin
        check("drop", longint'(drop), 1);
        void'(dq.pop_front());
      end else begin
        check("idle_drop", longint'(drop), 0);
      end
    end
  end

  initial begin
    longint ar[3], ai[3], yr[3], yi[3];
    rst_n = 1'b0;
    in_reset = 1'b1;
    din_dr = '0;
    din_di = '0;
    din_dv = 1'b0;
    sync_in = 1'b0;
    inv = 1'b0;
    midx = 0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    #2;
    rst_n = 1'b1;
    in_reset = 1'b0;

    // hand-computed anchors for the model
    ar = '{1000, 1000, 1000}; ai = '{0, 0, 0};
    dft3(ar, ai, 1'b0, yr, yi);
    check("model_dc_x0r", yr[0], 3000);
    check("model_dc_x1r", yr[1], 0);
    check("model_dc_x2i", yi[2], 0);
    ar = '{0, 1000, 0};
    dft3(ar, ai, 1'b0, yr, yi);
    check("model_fwd_x0r", yr[0], 1000);
    check("model_fwd_x1r", yr[1], -500);
    check("model_fwd_x1i", yi[1], -866);
    check("model_fwd_x2i", yi[2], 866);
    dft3(ar, ai, 1'b1, yr, yi);
    check("model_inv_x1i", yi[1], 866);
    check("model_inv_x2i", yi[2], -866);
    ar = '{-131072, -131072, -131072}; ai = ar;
    dft3(ar, ai, 1'b0, yr, yi);
    check("model_min_x0r", yr[0], -393216);
    check("model_min_x0i", yi[0], -393216);
    check("model_min_x1r", yr[1], 0);

    // directed triplets, back to back
    send(1000, 0, 1, 0); send(1000, 0, 0, 0); send(1000, 0, 0, 0);
    send(0, 0, 1, 0);    send(1000, 0, 0, 0); send(0, 0, 0, 0);
    send(0, 0, 0, 1);    send(1000, 0, 0, 0); send(0, 0, 0, 0);
    send(-131072, -131072, 1, 0); send(-131072, -131072, 0, 0); send(-131072, -131072, 0, 0);
    idle(3);

    // resync on the third sample: partial triplet dropped, inv only taken from x0
    send(5, 6, 1, 0); send(7, 8, 0, 0); send(100, -200, 1, 0);
    send(300, 400, 0, 0); send(-50, 25, 0, 1);
    idle(2);

    // valid every third cycle
    for (int n = 0; n < 6; n++) begin
      send(rnd_val(), rnd_val(), n == 0, 1'b0);
      idle(2);
    end

    // reset with one triplet emitting and the next one half collected
    send(1234, -77, 0, 0); send(-900, 45, 0, 0); send(333, 2000, 0, 0);
    send(11, 22, 0, 0); send(33, 44, 0, 0);
    idle(2);
    do_reset(2);
    idle(8);
    send(-7000, 123, 0, 0); send(4000, -4000, 0, 0); send(17, 19, 0, 1);
    idle(3);

    // randomized traffic with resyncs, gaps and mode changes
    for (int n = 0; n < 450; n++) begin
      bit sy;
      sy = (midx == 0) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 19) == 0);
      send(rnd_val(), rnd_val(), sy, 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    idle(12);
    check("pending_outputs", longint'(eq.size()), 0);
    check("pending_drops", longint'(dq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
